// File: rtl/ph_fifo_if.sv
// Parasite write port and host read port of the parasite-to-host Tube FIFO.
// The master modport drives accesses; the slave modport is the FIFO.
interface ph_fifo_if #(
    parameter int unsigned DW = 8
);
    logic          p_selectData;
    logic          p_rdnw;
    logic [DW-1:0] p_data;
    logic          p_full;
    logic          h_selectData;
    logic          h_rdnw;
    logic [DW-1:0] h_data;
    logic          h_data_available;

    modport master (
        output p_selectData, p_rdnw, p_data, h_selectData, h_rdnw,
        input  p_full, h_data, h_data_available
    );

    modport slave (
        input  p_selectData, p_rdnw, p_data, h_selectData, h_rdnw,
        output p_full, h_data, h_data_available
    );
endinterface

// File: rtl/ph_fifo.sv
// Parasite-to-host byte FIFO for Tube register 1. Slot occupancy is carried by per-slot
// toggle pairs, so only single-bit toggles ever cross between the two unrelated clocks.
module ph_fifo #(
    parameter int unsigned DEPTH       = 24,
    parameter int unsigned DW          = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic      h_rst_b,
    input logic      h_phi2,
    input logic      p_phi2,
    ph_fifo_if.slave bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [DW-1:0]                     mem_q [DEPTH];
    logic [DEPTH-1:0]                  wtog_q;
    logic [DEPTH-1:0]                  rtog_q;
    logic [AW-1:0]                     wptr_q;
    logic [AW-1:0]                     rptr_q;
    logic [AW-1:0]                     wptr_d;
    logic [AW-1:0]                     rptr_d;
    logic [SYNC_STAGES-1:0][DEPTH-1:0] rtog_sync_p_q;
    logic [SYNC_STAGES-1:0][DEPTH-1:0] wtog_sync_h_q;
    logic [DEPTH-1:0]                  rtog_seen_p;
    logic [DEPTH-1:0]                  wtog_seen_h;
    logic                              full;
    logic                              avail;
    logic                              do_write;
    logic                              do_read;

    assign rtog_seen_p = rtog_sync_p_q[SYNC_STAGES-1];
    assign wtog_seen_h = wtog_sync_h_q[SYNC_STAGES-1];

    // Each side compares its own live toggle against the delayed copy of the other side's,
    // so both flags can only lag toward the safe direction.
    assign full  = wtog_q[wptr_q] != rtog_seen_p[wptr_q];
    assign avail = wtog_seen_h[rptr_q] != rtog_q[rptr_q];

    assign do_write = bus.p_selectData & ~bus.p_rdnw & ~full;
    assign do_read  = bus.h_selectData & bus.h_rdnw & avail;

    assign wptr_d = (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
    assign rptr_d = (rptr_q == LAST) ? '0 : rptr_q + 1'b1;

    assign bus.p_full           = full;
    assign bus.h_data_available = avail;
    assign bus.h_data           = mem_q[rptr_q];

    // Parasite domain: write pointer, write toggles, and the read-toggle synchroniser.
    always_ff @(negedge p_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            wtog_q        <= '0;
            wptr_q        <= '0;
            rtog_sync_p_q <= '0;
        end else begin
            rtog_sync_p_q <= {rtog_sync_p_q[SYNC_STAGES-2:0], rtog_q};
            if (do_write) begin
                wtog_q[wptr_q] <= ~wtog_q[wptr_q];
                wptr_q         <= wptr_d;
            end
        end
    end

    // Storage lives in the parasite domain; a slot is only written while the host sees it empty.
    always_ff @(negedge p_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_write) begin
            mem_q[wptr_q] <= bus.p_data;
        end
    end

    // Host domain: read pointer, read toggles, and the write-toggle synchroniser.
    always_ff @(negedge h_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            rtog_q        <= '0;
            rptr_q        <= '0;
            wtog_sync_h_q <= '0;
        end else begin
            wtog_sync_h_q <= {wtog_sync_h_q[SYNC_STAGES-2:0], wtog_q};
            if (do_read) begin
                rtog_q[rptr_q] <= ~rtog_q[rptr_q];
                rptr_q         <= rptr_d;
            end
        end
    end
endmodule
